// File: rtl/panel_seq_pkg.sv
// Shared definitions for the panel power sequencer: state encoding,
// CSR offsets, CTRL bit positions and per-state output decode.
package panel_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_VDD    = 3'd1,
    ST_PD     = 3'd2,
    ST_RST    = 3'd3,
    ST_ON     = 3'd4,
    ST_BLOFF  = 3'd5,
    ST_BROFF  = 3'd6,
    ST_VDDOFF = 3'd7
  } state_e;

  localparam logic [4:0] OFS_CTRL = 5'd0;
  localparam logic [4:0] OFS_T_UP = 5'd1;
  localparam logic [4:0] OFS_T_DN = 5'd2;

  localparam int CTRL_ON_REQ    = 0;
  localparam int CTRL_BUSY      = 4;
  localparam int CTRL_IRQ_EN    = 6;
  localparam int CTRL_IRQ_PEND  = 7;

  // Pin pattern per state, packed as {vdd, pd_n, rst_n, bklt_en, pwm_gate}.
  function automatic logic [4:0] outs_for(input state_e s);
    case (s)
      ST_VDD:    outs_for = 5'b10000;
      ST_PD:     outs_for = 5'b11000;
      ST_RST:    outs_for = 5'b11100;
      ST_ON:     outs_for = 5'b11111;
      ST_BLOFF:  outs_for = 5'b11100;
      ST_BROFF:  outs_for = 5'b10000;
      default:   outs_for = 5'b00000;
    endcase
  endfunction

  function automatic logic is_timed(input state_e s);
    is_timed = (s != ST_OFF) && (s != ST_ON);
  endfunction

  function automatic logic is_up_step(input state_e s);
    is_up_step = (s == ST_VDD) || (s == ST_PD) || (s == ST_RST);
  endfunction

endpackage

// File: rtl/panel_seq_timer.sv
// Step timer: ce_tick prescaler feeding an 8-bit down-counter that
// saturates at zero; done is high while the count is zero.
module panel_seq_timer #(
  parameter int PRESC_DIV = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ce_tick,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_done
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_cnt;

  // Prescaler and step counter; a load restarts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_cnt   <= 8'd0;
    end else if (i_load) begin
      r_presc <= '0;
      r_cnt   <= i_value;
    end else if (i_ce_tick) begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end
      end else begin
        r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_done = (r_cnt == 8'd0);

endmodule

// File: rtl/panel_seq.sv
// Timed eDP/LVDS panel power sequencer with CSR interface.
// Optional completion interrupt enabled by defining PANEL_SEQ_IRQ_EN.
module panel_seq
  import panel_seq_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h1c,
  parameter logic [7:0] DFL_T_UP  = 8'd10,
  parameter logic [7:0] DFL_T_DN  = 8'd10,
  parameter int         PRESC_DIV = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_tick,
  output logic       lcd_vdd_en,
  output logic       ptn_pd_n,
  output logic       ptn_rst_n,
  output logic       bklt_en,
  output logic       pwm_gate,
  output logic       irq
);

  localparam logic [4:0] A_CTRL = BASE_ADDR + OFS_CTRL;
  localparam logic [4:0] A_T_UP = BASE_ADDR + OFS_T_UP;
  localparam logic [4:0] A_T_DN = BASE_ADDR + OFS_T_DN;

  state_e     r_state;
  state_e     w_state_next;
  logic       r_on_req;
  logic [7:0] r_t_up;
  logic [7:0] r_t_dn;
  logic [4:0] r_outs;
  logic       w_done;
  logic       w_load;
  logic       w_busy;
  logic       w_wr_ctrl;
  logic [7:0] w_ctrl_rd;

  assign w_wr_ctrl = csr_we && (csr_a == A_CTRL);
  assign w_busy    = (r_state != ST_OFF) && (r_state != ST_ON);
  assign w_load    = (w_state_next != r_state) && is_timed(w_state_next);

  panel_seq_timer #(
    .PRESC_DIV (PRESC_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_ce_tick (ce_tick),
    .i_load    (w_load),
    .i_value   (is_up_step(w_state_next) ? r_t_up : r_t_dn),
    .o_done    (w_done)
  );

  // Next state; a dropped request aborts power-up straight to bridge-off.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF:    if (r_on_req) w_state_next = ST_VDD;    else w_state_next = ST_OFF;
      ST_VDD:    if (!r_on_req) w_state_next = ST_BROFF; else if (w_done) w_state_next = ST_PD;  else w_state_next = ST_VDD;
      ST_PD:     if (!r_on_req) w_state_next = ST_BROFF; else if (w_done) w_state_next = ST_RST; else w_state_next = ST_PD;
      ST_RST:    if (!r_on_req) w_state_next = ST_BROFF; else if (w_done) w_state_next = ST_ON;  else w_state_next = ST_RST;
      ST_ON:     if (!r_on_req) w_state_next = ST_BLOFF; else w_state_next = ST_ON;
      ST_BLOFF:  if (w_done) w_state_next = ST_BROFF;    else w_state_next = ST_BLOFF;
      ST_BROFF:  if (w_done) w_state_next = ST_VDDOFF;   else w_state_next = ST_BROFF;
      ST_VDDOFF: if (w_done) w_state_next = ST_OFF;      else w_state_next = ST_VDDOFF;
      default:   w_state_next = ST_OFF;
    endcase
  end

  // State, pin outputs and CSR fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_OFF;
      r_outs   <= 5'b00000;
      r_on_req <= 1'b0;
      r_t_up   <= DFL_T_UP;
      r_t_dn   <= DFL_T_DN;
    end else begin
      r_state <= w_state_next;
      r_outs  <= outs_for(w_state_next);
      if (w_wr_ctrl) r_on_req <= csr_di[CTRL_ON_REQ];
      if (csr_we && (csr_a == A_T_UP)) r_t_up <= csr_di;
      if (csr_we && (csr_a == A_T_DN)) r_t_dn <= csr_di;
    end
  end

  assign {lcd_vdd_en, ptn_pd_n, ptn_rst_n, bklt_en, pwm_gate} = r_outs;

`ifdef PANEL_SEQ_IRQ_EN
  logic r_irq_en;
  logic r_irq_pend;
  logic r_irq;
  logic w_en_next;
  logic w_pend_next;

  // Interrupt fields; a completion event in the same cycle beats the w1c.
  always_comb begin
    w_en_next   = r_irq_en;
    w_pend_next = r_irq_pend;
    if (w_wr_ctrl) begin
      w_en_next = csr_di[CTRL_IRQ_EN];
      if (csr_di[CTRL_IRQ_PEND]) w_pend_next = 1'b0;
      else                       w_pend_next = r_irq_pend;
    end else begin
      w_en_next = r_irq_en;
    end
    if ((w_state_next != r_state) && ((w_state_next == ST_ON) || (w_state_next == ST_OFF))) begin
      w_pend_next = 1'b1;
    end else begin
      w_pend_next = w_pend_next;
    end
  end

  // Interrupt registers; irq is registered from the next-cycle field values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_en   <= w_en_next;
      r_irq_pend <= w_pend_next;
      r_irq      <= w_en_next & w_pend_next;
    end
  end

  assign irq       = r_irq;
  assign w_ctrl_rd = {r_irq_pend, r_irq_en, 1'b0, w_busy, r_state, r_on_req};
`else
  assign irq       = 1'b0;
  assign w_ctrl_rd = {2'b00, 1'b0, w_busy, r_state, r_on_req};
`endif

  // Read mux; zero when not addressed so it can be OR-ed onto the bus.
  always_comb begin
    csr_do = 8'h00;
    if (csr_a == A_CTRL)      csr_do = w_ctrl_rd;
    else if (csr_a == A_T_UP) csr_do = r_t_up;
    else if (csr_a == A_T_DN) csr_do = r_t_dn;
    else                      csr_do = 8'h00;
  end

endmodule

// File: tb/tb_panel_seq.sv
// Directed self-checking bench for panel_seq; expectations follow
// PANEL_SEQ_IRQ_EN when it is defined.
module tb_panel_seq;

  localparam logic [4:0] BASE = 5'h1c;
`ifdef PANEL_SEQ_IRQ_EN
  localparam logic       IRQ_ON = 1'b1;
`else
  localparam logic       IRQ_ON = 1'b0;
`endif
  localparam logic [7:0] P = IRQ_ON ? 8'h80 : 8'h00;
  localparam logic [7:0] E = IRQ_ON ? 8'h40 : 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'd0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic       ce_tick = 1'b0;
  logic       lcd_vdd_en, ptn_pd_n, ptn_rst_n, bklt_en, pwm_gate, irq;
  logic [4:0] outs;
  int         checks = 0;
  int         failures = 0;
  int         bklt_cycles = 0;
  int         bklt_mark = 0;

  assign outs = {lcd_vdd_en, ptn_pd_n, ptn_rst_n, bklt_en, pwm_gate};

  panel_seq dut (
    .clk        (clk),
    .rst        (rst),
    .csr_a      (csr_a),
    .csr_di     (csr_di),
    .csr_we     (csr_we),
    .csr_do     (csr_do),
    .ce_tick    (ce_tick),
    .lcd_vdd_en (lcd_vdd_en),
    .ptn_pd_n   (ptn_pd_n),
    .ptn_rst_n  (ptn_rst_n),
    .bklt_en    (bklt_en),
    .pwm_gate   (pwm_gate),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bklt_en) bklt_cycles <= bklt_cycles + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(tag, csr_do, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(posedge clk);
    #1;
    csr_we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step(3);
    rst = 1'b0;
    chk("rst_outs", {3'b000, outs}, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rd("rst_ctrl", BASE, 8'h00);
    rd("rst_tup", BASE + 5'd1, 8'h0a);
    rd("rst_tdn", BASE + 5'd2, 8'h0a);
    rd("rst_unmapped", BASE + 5'd3, 8'h00);

    // Power-up with T_UP=2: 65-clk steps
    ce_tick = 1'b1;
    wr(BASE + 5'd1, 8'd2);
    wr(BASE, 8'h01);
    chk("up_write_edge", {3'b000, outs}, 8'h00);
    step(1);  chk("up_vdd", {3'b000, outs}, 8'h10);
    step(64); chk("up_vdd_hold", {3'b000, outs}, 8'h10);
    step(1);  chk("up_pd", {3'b000, outs}, 8'h18);
    rd("up_ctrl_pd", BASE, 8'h15);
    step(64); chk("up_pd_hold", {3'b000, outs}, 8'h18);
    step(1);  chk("up_rst", {3'b000, outs}, 8'h1c);
    step(64); chk("up_rst_hold", {3'b000, outs}, 8'h1c);
    step(1);  chk("up_on", {3'b000, outs}, 8'h1f);
    rd("up_ctrl_on", BASE, 8'h09 | P);

    // Power-down with T_DN=1: 33-clk steps
    wr(BASE + 5'd2, 8'd1);
    wr(BASE, 8'h00);
    chk("dn_write_edge", {3'b000, outs}, 8'h1f);
    step(1);  chk("dn_bloff", {3'b000, outs}, 8'h1c);
    rd("dn_ctrl_bloff", BASE, 8'h1a | P);
    step(32); chk("dn_bloff_hold", {3'b000, outs}, 8'h1c);
    step(1);  chk("dn_broff", {3'b000, outs}, 8'h10);
    rd("dn_ctrl_broff", BASE, 8'h1c | P);
    step(32); chk("dn_broff_hold", {3'b000, outs}, 8'h10);
    step(1);  chk("dn_vddoff", {3'b000, outs}, 8'h00);
    rd("dn_ctrl_vddoff", BASE, 8'h1e | P);
    step(32); rd("dn_ctrl_vddoff_hold", BASE, 8'h1e | P);
    step(1);  rd("dn_ctrl_off", BASE, 8'h00 | P);

    // Abort from PD, then request during VDDOFF
    bklt_mark = bklt_cycles;
    wr(BASE + 5'd1, 8'd1);
    wr(BASE, 8'h01);
    step(1);  chk("ab_vdd", {3'b000, outs}, 8'h10);
    step(33); chk("ab_pd", {3'b000, outs}, 8'h18);
    step(5);
    wr(BASE, 8'h00);
    step(1);  chk("ab_broff", {3'b000, outs}, 8'h10);
    rd("ab_ctrl_broff", BASE, 8'h1c | P);
    step(33); chk("ab_vddoff", {3'b000, outs}, 8'h00);
    rd("ab_ctrl_vddoff", BASE, 8'h1e | P);
    step(3);
    wr(BASE, 8'h01);
    step(28); rd("ab_req_ignored", BASE, 8'h1f | P);
    step(1);  rd("ab_off_first", BASE, 8'h01 | P);
    chk("ab_off_outs", {3'b000, outs}, 8'h00);
    step(1);  rd("ab_restart_vdd", BASE, 8'h13 | P);
    chk("ab_restart_outs", {3'b000, outs}, 8'h10);
    chk("ab_bklt_never", 8'(bklt_cycles - bklt_mark), 8'h00);

    // Reset mid-sequence is abrupt and restores defaults
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_outs", {3'b000, outs}, 8'h00);
    rd("mid_rst_tup", BASE + 5'd1, 8'h0a);
    rd("mid_rst_ctrl", BASE, 8'h00);

    // T_UP=0: one clk per power-up step
    wr(BASE + 5'd1, 8'd0);
    wr(BASE, 8'h01);
    step(1); chk("z_vdd", {3'b000, outs}, 8'h10);
    step(1); chk("z_pd", {3'b000, outs}, 8'h18);
    step(1); chk("z_rst", {3'b000, outs}, 8'h1c);
    step(1); chk("z_on", {3'b000, outs}, 8'h1f);
    rd("z_ctrl_on", BASE, 8'h09 | P);
    chk("z_irq_masked", {7'd0, irq}, 8'h00);

    // Interrupt enable, w1c clear, and completion on reaching OFF
    wr(BASE, 8'h41);
    chk("irq_enabled", {7'd0, irq}, {7'd0, IRQ_ON});
    rd("irq_ctrl_en", BASE, 8'h09 | P | E);
    wr(BASE, 8'hc1);
    chk("irq_cleared", {7'd0, irq}, 8'h00);
    rd("irq_ctrl_clr", BASE, 8'h09 | E);
    wr(BASE + 5'd2, 8'd1);
    wr(BASE, 8'h40);
    rd("irq_ctrl_dn", BASE, 8'h08 | E);
    step(99); chk("irq_before_off", {7'd0, irq}, 8'h00);
    step(1);  chk("irq_at_off", {7'd0, irq}, {7'd0, IRQ_ON});
    rd("irq_ctrl_off", BASE, 8'h00 | P | E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
